math_add_48_arb: RTL and testbench
==================================

// Module: math_add_48_arb
//
// PURPOSE
//   Shares one math_add_48 instance between NUM_REQ independent requesters.
//   Each requester offers an operand pair on a valid/ready handshake.
//   A round-robin arbiter issues at most one operation per cycle into the adder.
//   A tag pipeline, matched to the adder latency, returns each sum with the ID of its requester.
//   Used wherever several low-duty-cycle accumulate/offset paths share a single DSP slice.
//
// PARAMETERS
//   NUM_REQ     4   number of requesters, 2..16
//   USE_FABRIC  0   forwarded to math_add_48; 0 = DSP (2-cycle latency), 1 = fabric (1-cycle latency)
//   ID_W        -   localparam, $clog2(NUM_REQ)
//   ADD_LAT     -   localparam, USE_FABRIC ? 1 : 2
//
// PORTS
//   clk        in   1            clock
//   rst_n      in   1            asynchronous reset, active-low
//   req_valid  in   NUM_REQ      per-requester operand valid
//   req_ready  out  NUM_REQ      per-requester accept, one-hot or zero
//   req_dina   in   NUM_REQ*48   packed operand A; requester i occupies [48*i +: 48]
//   req_dinb   in   NUM_REQ*48   packed operand B, same packing as req_dina
//   res_valid  out  1            result strobe, single cycle, no backpressure
//   res_id     out  ID_W         requester index owning res_sum
//   res_sum    out  49           dina + dinb, unsigned, bit 48 = carry
//   busy       out  1            high while any accepted operation has not yet produced a result
//
// BEHAVIOUR
//   - Reset values: req_ready = 0, res_valid = 0, res_id = 0, busy = 0; rr pointer = 0.
//   - Handshake:
//     - A transfer occurs on requester i when req_valid[i] & req_ready[i] at a rising clk edge.
//     - req_valid, once high, must hold its value, with operands stable, until the transfer.
//   - Arbitration:
//     - Start at index ptr and pick the first i, scanning upward modulo NUM_REQ, with req_valid[i] = 1.
//     - req_ready is the one-hot of that i. It is combinational from req_valid and ptr.
//     - On a transfer, ptr <= (i+1) mod NUM_REQ. With NUM_REQ = 4, i = 3 wraps ptr to 0.
//     - With no valid request, req_ready = 0 and ptr holds.
//   - Issue stage:
//     - On a transfer, the granted operands and ID are registered into the issue register.
//     - The issue-valid flag is set for one cycle; with no transfer it is cleared.
//     - One transfer per cycle maximum, so full throughput is 1 op/cycle with no bubbles.
//   - Adder:
//     - math_add_48 takes ena = 1 constantly and rst = ~rst_n.
//     - Operands are driven from the issue register.
//     - Results are qualified only by the tag pipeline, never by adder contents.
//   - Tag pipeline:
//     - A shift register of depth ADD_LAT carries {valid, id}. Its output drives res_valid and res_id.
//     - It is reset asynchronously to all-zero.
//   - Latency: transfer edge to res_valid high is ADD_LAT + 1 cycles (DSP 3, fabric 2).
//   - busy: OR of issue-valid and every tag-pipeline valid bit. The combinational request path is excluded.
//   - Simultaneous events:
//     - A new transfer and an emerging result in the same cycle are independent; both proceed.
//   - Reset mid-operation:
//     - All in-flight tags are dropped and no res_valid is produced for them.
//     - ptr returns to 0. Requesters must re-present their requests.
//   - Width rules:
//     - The sum is unsigned, 49 bits. Bit 48 is the carry; no saturation.
//     - Signed users ignore bit 48 and take [47:0] as two's-complement wrap.
//
// STRUCTURE
//   - Shared package math_pkg holds:
//     - MATH_ADD48_W = 48, the operand width;
//     - the function add48_lat(use_fabric) returning 1 or 2;
//     - the typedef add48_tag_t = struct {logic vld; logic [ID_W-1:0] id;}.
//   - One sub-module, rr_arb_onehot: round-robin one-hot grant from (req, ptr).
//     - Parameterised on NUM_REQ and reused by other shared-resource arbiters.
//   - math_add_48 is instantiated unchanged. Operand mux, issue register, tag pipeline and ptr are inline.
//
// TESTING
//   1. Reset, then req0 = {0x0000_0000_0001, 0x0000_0000_0002} only
//      -> req_ready = 0001 same cycle;
//      -> res_valid @ +3 (DSP) / +2 (fabric);
//      -> res_id = 0, res_sum = 0x0_0000_0000_0003.
//   2. All 4 valid, held continuously for 8 cycles
//      -> grant order 0,1,2,3,0,1,2,3;
//      -> res_valid high on every cycle once the pipeline fills;
//      -> res_id follows the same order; busy stays high.
//   3. dina = dinb = 0xFFFF_FFFF_FFFF on req2
//      -> res_sum = 0x1_FFFF_FFFF_FFFE, res_id = 2.
//   4. ptr = 3 after grant to req2; req1 and req3 valid
//      -> req3 granted first, then req1; ptr wraps 3 -> 0 -> 2.
//   5. Assert rst_n = 0 one cycle after two transfers
//      -> all outputs 0 asynchronously; no res_valid after release;
//      -> the next single request is granted from index 0 scan.
//   6. Requests gapped by idle cycles
//      -> busy falls exactly ADD_LAT + 1 cycles after the last transfer;
//      -> req_ready = 0 and ptr unchanged while idle.

Source files
------------

// File: rtl/math_pkg.sv
// Shared definitions for the 48-bit adder family.
//   MATH_ADD48_W  : operand width
//   MATH_TAG_ID_W : requester-ID field width in a tag, sized for up to 16 requesters
//   add48_lat()   : adder latency for the selected implementation
//   add48_tag_t   : {vld, id} record carried alongside an in-flight addition
package math_pkg;

   localparam int unsigned MATH_ADD48_W  = 48;
   localparam int unsigned MATH_TAG_ID_W = 4;

   function automatic int unsigned add48_lat(input int unsigned use_fabric);
      return (use_fabric != 0) ? 1 : 2;
   endfunction

   typedef struct packed {
      logic                     vld;
      logic [MATH_TAG_ID_W-1:0] id;
   } add48_tag_t;

endpackage

// File: rtl/math_add_48.sv
// 48-bit unsigned adder producing a 49-bit sum (bit 48 = carry).
//   clk  : clock
//   rst  : synchronous reset, active-high
//   ena  : clock enable for all pipeline registers
//   dina : operand A
//   dinb : operand B
//   dout : dina + dinb, available after 1 (fabric) or 2 (DSP) clocks
module math_add_48
   import math_pkg::*;
#(
   parameter int unsigned USE_FABRIC = 0
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    ena,
   input  logic [MATH_ADD48_W-1:0] dina,
   input  logic [MATH_ADD48_W-1:0] dinb,
   output logic [MATH_ADD48_W:0]   dout
);

   generate
      if (USE_FABRIC != 0) begin : g_fabric
         always_ff @(posedge clk) begin
            if (rst) begin
               dout <= '0;
            end else if (ena) begin
               dout <= {1'b0, dina} + {1'b0, dinb};
            end
         end
      end else begin : g_dsp
         // Input register then output register, matching a DSP slice A/B + P stage.
         logic [MATH_ADD48_W-1:0] a_r;
         logic [MATH_ADD48_W-1:0] b_r;

         always_ff @(posedge clk) begin
            if (rst) begin
               a_r  <= '0;
               b_r  <= '0;
               dout <= '0;
            end else if (ena) begin
               a_r  <= dina;
               b_r  <= dinb;
               dout <= {1'b0, a_r} + {1'b0, b_r};
            end
         end
      end
   endgenerate

endmodule

// File: rtl/rr_arb_onehot.sv
// Combinational round-robin arbiter.
//   req       : request vector
//   ptr       : highest-priority index; scanning proceeds upward modulo NUM_REQ
//   grant     : one-hot grant, zero when no request
//   grant_idx : binary index of the granted requester (0 when none)
//   grant_vld : any request granted
module rr_arb_onehot #(
   parameter int unsigned NUM_REQ = 4,
   parameter int unsigned ID_W    = $clog2(NUM_REQ)
) (
   input  logic [NUM_REQ-1:0] req,
   input  logic [ID_W-1:0]    ptr,
   output logic [NUM_REQ-1:0] grant,
   output logic [ID_W-1:0]    grant_idx,
   output logic               grant_vld
);

   always_comb begin
      int unsigned idx;
      logic [ID_W-1:0] idx_w;
      grant     = '0;
      grant_idx = '0;
      grant_vld = 1'b0;
      idx       = 0;
      idx_w     = '0;
      // Walk offsets from farthest to nearest so the nearest requester to ptr wins.
      for (int unsigned k = NUM_REQ; k > 0; k--) begin
         idx   = (32'(ptr) + k - 1) % NUM_REQ;
         idx_w = idx[ID_W-1:0];
         if (req[idx_w]) begin
            grant        = '0;
            grant[idx_w] = 1'b1;
            grant_idx    = idx_w;
            grant_vld    = 1'b1;
         end
      end
   end

endmodule

// File: rtl/math_add_48_arb.sv
// Shares one math_add_48 between NUM_REQ requesters.
//   clk       : clock
//   rst_n     : asynchronous reset, active-low
//   req_valid : per-requester operand valid
//   req_ready : per-requester accept (one-hot or zero), combinational from req_valid and ptr
//   req_dina  : packed operand A, requester i at [48*i +: 48]
//   req_dinb  : packed operand B, same packing
//   res_valid : single-cycle result strobe
//   res_id    : requester owning res_sum
//   res_sum   : 49-bit unsigned sum, bit 48 = carry
//   busy      : an accepted operation has not yet produced its result
module math_add_48_arb
   import math_pkg::*;
#(
   parameter  int unsigned NUM_REQ    = 4,
   parameter  int unsigned USE_FABRIC = 0,
   localparam int unsigned ID_W       = $clog2(NUM_REQ),
   localparam int unsigned ADD_LAT    = add48_lat(USE_FABRIC)
) (
   input  logic                           clk,
   input  logic                           rst_n,
   input  logic [NUM_REQ-1:0]             req_valid,
   output logic [NUM_REQ-1:0]             req_ready,
   input  logic [NUM_REQ*MATH_ADD48_W-1:0] req_dina,
   input  logic [NUM_REQ*MATH_ADD48_W-1:0] req_dinb,
   output logic                           res_valid,
   output logic [ID_W-1:0]                res_id,
   output logic [MATH_ADD48_W:0]          res_sum,
   output logic                           busy
);

   localparam logic [ID_W-1:0] LAST_IDX = ID_W'(NUM_REQ - 1);

   logic [NUM_REQ-1:0]      grant;
   logic [ID_W-1:0]         gnt_idx;
   logic                    gnt_vld;
   logic                    xfer;
   logic [ID_W-1:0]         ptr;

   logic [MATH_ADD48_W-1:0] mux_a;
   logic [MATH_ADD48_W-1:0] mux_b;

   logic                    iss_vld;
   logic [ID_W-1:0]         iss_id;
   logic [MATH_ADD48_W-1:0] iss_a;
   logic [MATH_ADD48_W-1:0] iss_b;

   logic [MATH_ADD48_W:0]   add_sum;

   add48_tag_t              tag_in;
   add48_tag_t              tag_q [ADD_LAT];

   // ---------------- arbitration ----------------
   rr_arb_onehot #(
      .NUM_REQ (NUM_REQ),
      .ID_W    (ID_W)
   ) u_arb (
      .req       (req_valid),
      .ptr       (ptr),
      .grant     (grant),
      .grant_idx (gnt_idx),
      .grant_vld (gnt_vld)
   );

   // Ready is held low while reset is asserted so nothing is accepted then.
   always_comb begin
      req_ready = rst_n ? grant : '0;
      xfer      = gnt_vld & rst_n;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ptr <= '0;
      end else if (xfer) begin
         ptr <= (gnt_idx == LAST_IDX) ? '0 : gnt_idx + 1'b1;
      end
   end

   // ---------------- operand mux ----------------
   always_comb begin
      mux_a = '0;
      mux_b = '0;
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
         if (grant[i]) begin
            mux_a = req_dina[MATH_ADD48_W*i +: MATH_ADD48_W];
            mux_b = req_dinb[MATH_ADD48_W*i +: MATH_ADD48_W];
         end
      end
   end

   // ---------------- issue register ----------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         iss_vld <= 1'b0;
         iss_id  <= '0;
         iss_a   <= '0;
         iss_b   <= '0;
      end else begin
         iss_vld <= xfer;
         if (xfer) begin
            iss_id <= gnt_idx;
            iss_a  <= mux_a;
            iss_b  <= mux_b;
         end
      end
   end

   // ---------------- shared adder ----------------
   math_add_48 #(
      .USE_FABRIC (USE_FABRIC)
   ) u_add (
      .clk  (clk),
      .rst  (~rst_n),
      .ena  (1'b1),
      .dina (iss_a),
      .dinb (iss_b),
      .dout (add_sum)
   );

   // ---------------- tag pipeline ----------------
   // Depth equals the adder latency so each tag emerges with its sum.
   always_comb begin
      tag_in.vld = iss_vld;
      tag_in.id  = MATH_TAG_ID_W'(iss_id);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int unsigned i = 0; i < ADD_LAT; i++) begin
            tag_q[i] <= '0;
         end
      end else begin
         tag_q[0] <= tag_in;
         for (int unsigned i = 1; i < ADD_LAT; i++) begin
            tag_q[i] <= tag_q[i-1];
         end
      end
   end

   always_comb begin
      res_valid = tag_q[ADD_LAT-1].vld;
      res_id    = ID_W'(tag_q[ADD_LAT-1].id);
      res_sum   = add_sum;
   end

   always_comb begin
      busy = iss_vld;
      for (int unsigned i = 0; i < ADD_LAT; i++) begin
         busy = busy | tag_q[i].vld;
      end
   end

endmodule

// File: tb/tb_math_add_48_arb.sv
module tb_math_add_48_arb;

   localparam int unsigned N          = 4;
   localparam int unsigned USE_FABRIC = 0;
   localparam int unsigned LAT        = (USE_FABRIC != 0) ? 1 : 2;
   localparam int unsigned IDW        = 2;

   logic              clk = 1'b0;
   logic              rst_n;
   logic [N-1:0]      req_valid;
   logic [N-1:0]      req_ready;
   logic [N*48-1:0]   req_dina;
   logic [N*48-1:0]   req_dinb;
   logic              res_valid;
   logic [IDW-1:0]    res_id;
   logic [48:0]       res_sum;
   logic              busy;

   math_add_48_arb #(
      .NUM_REQ    (N),
      .USE_FABRIC (USE_FABRIC)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_dina  (req_dina),
      .req_dinb  (req_dinb),
      .res_valid (res_valid),
      .res_id    (res_id),
      .res_sum   (res_sum),
      .busy      (busy)
   );

   always #5 clk = ~clk;

   typedef struct {
      int unsigned id;
      logic [48:0] sum;
   } exp_t;

   typedef struct {
      int unsigned id;
      logic [47:0] a;
      logic [47:0] b;
      logic [48:0] e;
   } vec_t;

   exp_t        sb[$];
   exp_t        mon_e;
   int          total = 0;
   int          bad   = 0;
   logic        pend_v [N];
   logic [47:0] pend_a [N];
   logic [47:0] pend_b [N];
   logic [48:0] pend_e [N];
   int unsigned mptr;
   int          last_grant;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s act=%0h exp=%0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic apply();
      for (int i = 0; i < N; i++) begin
         req_valid[i]        = pend_v[i];
         req_dina[48*i +: 48] = pend_a[i];
         req_dinb[48*i +: 48] = pend_b[i];
      end
   endtask

   task automatic set_req(input int unsigned i, input logic [47:0] a, input logic [47:0] b,
                          input logic [48:0] e);
      pend_v[i] = 1'b1;
      pend_a[i] = a;
      pend_b[i] = b;
      pend_e[i] = e;
   endtask

   task automatic set_rand(input int unsigned i);
      logic [47:0] a;
      logic [47:0] b;
      a = 48'({$urandom(), $urandom()});
      b = 48'({$urandom(), $urandom()});
      set_req(i, a, b, {1'b0, a} + {1'b0, b});
   endtask

   function automatic int model_grant();
      for (int unsigned k = 0; k < N; k++) begin
         int unsigned j;
         j = (mptr + k) % N;
         if (pend_v[j]) return int'(j);
      end
      return -1;
   endfunction

   function automatic bit any_pend();
      for (int i = 0; i < N; i++) if (pend_v[i]) return 1'b1;
      return 1'b0;
   endfunction

   // One clock: present pending requests, check the grant, record the transfer.
   task automatic step();
      int         g;
      logic [N-1:0] exp_rdy;
      exp_t       e;
      apply();
      #1;
      g = model_grant();
      exp_rdy = '0;
      if (g >= 0) exp_rdy[g] = 1'b1;
      chk("req_ready", 64'(req_ready), 64'(exp_rdy));
      last_grant = g;
      if (g >= 0) begin
         e.id  = g;
         e.sum = pend_e[g];
         sb.push_back(e);
         pend_v[g] = 1'b0;
         mptr = (g + 1) % N;
      end
      @(negedge clk);
      apply();
   endtask

   task automatic clear_pend();
      for (int i = 0; i < N; i++) begin
         pend_v[i] = 1'b0;
         pend_a[i] = '0;
         pend_b[i] = '0;
         pend_e[i] = '0;
      end
   endtask

   task automatic drain();
      int guard;
      guard = 0;
      while (any_pend() && guard < 32) begin
         step();
         guard++;
      end
      chk("drain_bound", 64'(any_pend()), 64'(0));
      repeat (LAT + 2) step();
   endtask

   // Reset mid-cycle; outputs must clear without waiting for a clock edge.
   task automatic do_reset();
      #2;
      rst_n = 1'b0;
      #1;
      chk("rst_res_valid", 64'(res_valid), 64'(0));
      chk("rst_res_id", 64'(res_id), 64'(0));
      chk("rst_busy", 64'(busy), 64'(0));
      chk("rst_req_ready", 64'(req_ready), 64'(0));
      sb.delete();
      clear_pend();
      mptr = 0;
      apply();
      @(negedge clk);
      @(negedge clk);
      #2;
      rst_n = 1'b1;
      @(negedge clk);
   endtask

   always @(negedge clk) begin
      if (rst_n === 1'b1 && res_valid === 1'b1) begin
         if (sb.size() == 0) begin
            chk("unexpected_res", 64'(1), 64'(0));
         end else begin
            mon_e = sb.pop_front();
            chk("res_id", 64'(res_id), 64'(mon_e.id));
            chk("res_sum", 64'(res_sum), 64'(mon_e.sum));
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog act=timeout exp=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      vec_t tv [7];
      int   lat;
      int unsigned order [8];

      tv[0] = '{id: 0, a: 48'h0000_0000_0001, b: 48'h0000_0000_0002, e: 49'h0_0000_0000_0003};
      tv[1] = '{id: 2, a: 48'hFFFF_FFFF_FFFF, b: 48'hFFFF_FFFF_FFFF, e: 49'h1_FFFF_FFFF_FFFE};
      tv[2] = '{id: 1, a: 48'h8000_0000_0000, b: 48'h8000_0000_0000, e: 49'h1_0000_0000_0000};
      tv[3] = '{id: 3, a: 48'h0000_0000_0000, b: 48'h0000_0000_0000, e: 49'h0_0000_0000_0000};
      tv[4] = '{id: 1, a: 48'hFFFF_FFFF_FFFF, b: 48'h0000_0000_0001, e: 49'h1_0000_0000_0000};
      tv[5] = '{id: 3, a: 48'h1234_5678_9ABC, b: 48'h1111_1111_1111, e: 49'h0_2345_6789_ABCD};
      tv[6] = '{id: 0, a: 48'h7FFF_FFFF_FFFF, b: 48'h0000_0000_0001, e: 49'h0_8000_0000_0000};
      order = '{0, 1, 2, 3, 0, 1, 2, 3};

      // Reset state, with all requests raised to show ready is held off.
      rst_n = 1'b0;
      clear_pend();
      for (int i = 0; i < N; i++) pend_v[i] = 1'b1;
      apply();
      mptr = 0;
      last_grant = -1;
      do_reset();

      // Single request on req0: ready same cycle, result ADD_LAT+1 clocks later.
      set_req(0, 48'h0000_0000_0001, 48'h0000_0000_0002, 49'h0_0000_0000_0003);
      step();
      chk("t1_grant", 64'(last_grant), 64'(0));
      lat = 1;
      while (res_valid !== 1'b1 && lat < 20) begin
         step();
         lat++;
      end
      chk("t1_latency", 64'(lat), 64'(LAT + 1));
      drain();

      // Table vectors, back to back, one requester each.
      for (int k = 0; k < 7; k++) begin
         set_req(tv[k].id, tv[k].a, tv[k].b, tv[k].e);
         step();
         chk("tv_grant", 64'(last_grant), 64'(tv[k].id));
      end
      drain();

      // All four requesters held valid for 8 cycles.
      do_reset();
      for (int i = 0; i < N; i++) set_rand(i);
      for (int c = 0; c < 8; c++) begin
         step();
         chk("t2_order", 64'(last_grant), 64'(order[c]));
         chk("t2_busy", 64'(busy), 64'(1));
         if (c + 1 >= LAT + 1) chk("t2_res_valid", 64'(res_valid), 64'(1));
         for (int i = 0; i < N; i++) if (!pend_v[i]) set_rand(i);
      end
      drain();

      // Wrap: grant req2 (ptr->3), then req1+req3 -> 3 first, then 1 (ptr 0 -> 2).
      set_req(2, 48'h0000_0000_0010, 48'h0000_0000_0020, 49'h0_0000_0000_0030);
      step();
      chk("t4_first", 64'(last_grant), 64'(2));
      set_req(1, 48'h0000_0000_0100, 48'h0000_0000_0001, 49'h0_0000_0000_0101);
      set_req(3, 48'h0000_0000_0300, 48'h0000_0000_0003, 49'h0_0000_0000_0303);
      apply();
      #1;
      chk("t4_rdy3", 64'(req_ready), 64'(4'b1000));
      step();
      chk("t4_grant3", 64'(last_grant), 64'(3));
      #1;
      chk("t4_rdy1", 64'(req_ready), 64'(4'b0010));
      step();
      chk("t4_grant1", 64'(last_grant), 64'(1));
      set_rand(0);
      set_rand(2);
      set_rand(3);
      step();
      chk("t4_ptr2", 64'(last_grant), 64'(2));
      drain();

      // Reset one cycle after two transfers: in-flight results dropped, ptr back to 0.
      set_rand(1);
      set_rand(2);
      step();
      step();
      for (int i = 0; i < N; i++) pend_v[i] = 1'b1;
      apply();
      do_reset();
      repeat (6) step();
      set_rand(0);
      set_rand(3);
      step();
      chk("t5_scan0", 64'(last_grant), 64'(0));
      drain();
      set_rand(2);
      step();
      chk("t5_single", 64'(last_grant), 64'(2));
      drain();

      // Gapped requests: busy covers exactly ADD_LAT+1 cycles, ptr holds while idle.
      for (int r = 0; r < 3; r++) begin
         set_rand((r == 0) ? 1 : (r == 1) ? 3 : 0);
         step();
         for (int k = 0; k <= LAT + 1; k++) begin
            chk("t6_busy", 64'(busy), 64'(k <= LAT));
            step();
         end
      end
      set_rand(0);
      set_rand(2);
      step();
      chk("t6_ptr_hold", 64'(last_grant), 64'(2));
      drain();

      repeat (LAT + 3) step();
      chk("sb_empty", 64'(sb.size()), 64'(0));

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
